// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch mode controller.
// State codes, digit indices and button event priority.
package stopwatch_pkg;

  localparam int DIGIT_CNT = 4;
  localparam int SEL_W     = 2;

  localparam logic [2:0] ST_STOP = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_SET3 = 3'd2;
  localparam logic [2:0] ST_SET2 = 3'd3;
  localparam logic [2:0] ST_SET1 = 3'd4;
  localparam logic [2:0] ST_SET0 = 3'd5;

  localparam logic [SEL_W-1:0] DIG_HEX0 = 2'd0;
  localparam logic [SEL_W-1:0] DIG_HEX1 = 2'd1;
  localparam logic [SEL_W-1:0] DIG_HEX2 = 2'd2;
  localparam logic [SEL_W-1:0] DIG_HEX3 = 2'd3;

  // Highest first: set, start_stop, change.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_SET,
    EV_START,
    EV_CHANGE
  } btn_ev_e;

  function automatic btn_ev_e resolve_ev(
    input logic set_p,
    input logic ss_p,
    input logic chg_p
  );
    btn_ev_e ev;
    priority case (1'b1)
      set_p:   ev = EV_SET;
      ss_p:    ev = EV_START;
      chg_p:   ev = EV_CHANGE;
      default: ev = EV_NONE;
    endcase
    return ev;
  endfunction

  function automatic logic is_set(input logic [2:0] s);
    return (s == ST_SET3) || (s == ST_SET2) ||
           (s == ST_SET1) || (s == ST_SET0);
  endfunction

  function automatic logic [SEL_W-1:0] sel_of(input logic [2:0] s);
    logic [SEL_W-1:0] r;
    case (s)
      ST_SET3: r = DIG_HEX3;
      ST_SET2: r = DIG_HEX2;
      ST_SET1: r = DIG_HEX1;
      default: r = DIG_HEX0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] next_set(input logic [2:0] s);
    logic [2:0] r;
    case (s)
      ST_SET3: r = ST_SET2;
      ST_SET2: r = ST_SET1;
      ST_SET1: r = ST_SET0;
      default: r = ST_STOP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_button.sv
// Active-low button conditioner: 2-flop sync, debounce, press pulse.
// Presses are only armed once the button has been seen released after reset.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          press_q;
  logic          press_d;
  logic [1:0]    fill_q;
  logic [1:0]    fill_d;
  logic          armed_q;
  logic          armed_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // fill_q==2 means s2_q holds a real pin sample, not its reset value
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q |
              ((fill_q == 2'd2) & level_q & s2_q);
    press_d = armed_q & level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= btn_ni;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: run/stop, clear and digit SET mode
// with per-digit increment pulses and a blinking blank mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic                 clk100_i,
  input  logic                 rstn_i,
  input  logic                 start_stop_i,
  input  logic                 set_i,
  input  logic                 change_i,
  output logic                 run_o,
  output logic                 clr_o,
  output logic                 edit_o,
  output logic [SEL_W-1:0]     digit_sel_o,
  output logic                 inc_o,
  output logic [DIGIT_CNT-1:0] blank_o
);

  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);

  logic ss_press;
  logic set_press;
  logic chg_press;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_ss (
    .clk    (clk100_i),
    .rst_n  (rstn_i),
    .btn_ni (start_stop_i),
    .press_o(ss_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_set (
    .clk    (clk100_i),
    .rst_n  (rstn_i),
    .btn_ni (set_i),
    .press_o(set_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_chg (
    .clk    (clk100_i),
    .rst_n  (rstn_i),
    .btn_ni (change_i),
    .press_o(chg_press)
  );

  btn_ev_e       ev;
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic          clr_q;
  logic          clr_d;
  logic          inc_q;
  logic          inc_d;
  logic [BW-1:0] bcnt_q;
  logic [BW-1:0] bcnt_d;
  logic          phase_q;
  logic          phase_d;
  logic          in_set;
  logic [SEL_W-1:0] sel;

  assign ev     = resolve_ev(set_press, ss_press, chg_press);
  assign in_set = is_set(state_q);
  assign sel    = sel_of(state_q);

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    inc_d   = 1'b0;
    case (state_q)
      ST_STOP: begin
        unique case (ev)
          EV_SET:    state_d = ST_SET3;
          EV_START:  state_d = ST_RUN;
          EV_CHANGE: clr_d   = 1'b1;
          default:   state_d = state_q;
        endcase
      end
      ST_RUN: begin
        if (ev == EV_START) state_d = ST_STOP;
      end
      ST_SET3, ST_SET2, ST_SET1, ST_SET0: begin
        // start_stop wins over change here but is itself ignored
        unique case (ev)
          EV_SET:    state_d = next_set(state_q);
          EV_CHANGE: inc_d   = 1'b1;
          default:   state_d = state_q;
        endcase
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!in_set || ev == EV_SET) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BMAX) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_STOP;
      clr_q   <= 1'b0;
      inc_q   <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      inc_q   <= inc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    blank_o = '0;
    if (in_set && phase_q) blank_o[sel] = 1'b1;
  end

  assign run_o       = (state_q == ST_RUN);
  assign edit_o      = in_set;
  assign digit_sel_o = sel;
  assign clr_o       = clr_q;
  assign inc_o       = inc_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: per-feature tasks plus a pulse scoreboard
// (inc digit 0..3, clear = 4) popped by a negedge monitor.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ss = 1'b1;
  logic       st = 1'b1;
  logic       ch = 1'b1;
  logic       run_o;
  logic       clr_o;
  logic       edit_o;
  logic [1:0] digit_sel_o;
  logic       inc_o;
  logic [3:0] blank_o;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int mon_got;
  int mon_exp;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(1),
    .BLINK_CYCLES   (4)
  ) dut (
    .clk100_i    (clk),
    .rstn_i      (rstn),
    .start_stop_i(ss),
    .set_i       (st),
    .change_i    (ch),
    .run_o       (run_o),
    .clr_o       (clr_o),
    .edit_o      (edit_o),
    .digit_sel_o (digit_sel_o),
    .inc_o       (inc_o),
    .blank_o     (blank_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && (inc_o || clr_o)) begin
      mon_got = clr_o ? 4 : int'(digit_sel_o);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected got=%0d required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL pulse_kind got=%0d required=%0d", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      0: ss = 1'b0;
      1: st = 1'b0;
      default: ch = 1'b0;
    endcase
    tick(hold);
    ss = 1'b1;
    st = 1'b1;
    ch = 1'b1;
    tick(6);
  endtask

  task automatic wait_for_sel(input logic [1:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (edit_o && digit_sel_o == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick(2);
    total++;
    if ({run_o, clr_o, edit_o, inc_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000",
               {run_o, clr_o, edit_o, inc_o});
    end
    total++;
    if (digit_sel_o !== 2'd0 || blank_o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_sel_blank got=%0d/%b required=0/0000",
               digit_sel_o, blank_o);
    end
    rstn = 1'b1;
    tick(4);
    press(0, 1);
    total++;
    if (run_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_run_before got=%b required=1", run_o);
    end
    st = 1'b0;
    rstn = 1'b0;
    tick(2);
    total++;
    if ({run_o, edit_o, clr_o, inc_o, blank_o} !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_run got=%b required=00000000",
               {run_o, edit_o, clr_o, inc_o, blank_o});
    end
    rstn = 1'b1;
    tick(10);
    total++;
    if (edit_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_held_set got=%b required=0", edit_o);
    end
    st = 1'b1;
    tick(6);
    total++;
    if (edit_o !== 1'b0 || run_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b%b required=00", edit_o, run_o);
    end
  endtask

  task automatic test_start_stop;
    int toggles;
    logic prev;
    ss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if (run_o !== (i == 3)) begin
        bad++;
        $display("FAIL ss_latency_k%0d got=%b required=%b", i, run_o, i == 3);
      end
    end
    ss = 1'b1;
    tick(6);
    press(0, 1);
    total++;
    if (run_o !== 1'b0) begin
      bad++;
      $display("FAIL ss_second got=%b required=0", run_o);
    end
    toggles = 0;
    prev = run_o;
    ss = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i == 20) ss = 1'b1;
      tick(1);
      if (run_o !== prev) toggles++;
      prev = run_o;
    end
    total++;
    if (toggles != 1 || run_o !== 1'b1) begin
      bad++;
      $display("FAIL ss_hold got=%0d/%b required=1/1", toggles, run_o);
    end
    press(0, 1);
    total++;
    if (run_o !== 1'b0) begin
      bad++;
      $display("FAIL ss_stop got=%b required=0", run_o);
    end
  endtask

  task automatic test_set_inc;
    press(1, 1);
    total++;
    if (edit_o !== 1'b1 || digit_sel_o !== 2'd3) begin
      bad++;
      $display("FAIL set3_entry got=%b/%0d required=1/3", edit_o, digit_sel_o);
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(3);
      press(2, 1);
    end
    press(1, 1);
    total++;
    if (digit_sel_o !== 2'd2) begin
      bad++;
      $display("FAIL set2_entry got=%0d required=2", digit_sel_o);
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(2);
      press(2, 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL inc_missing got=%0d required=0", exp_q.size());
    end
    for (int i = 0; i < 3; i++) press(1, 1);
    total++;
    if ({edit_o, run_o, digit_sel_o, blank_o} !== 8'h00) begin
      bad++;
      $display("FAIL set_exit got=%b required=00000000",
               {edit_o, run_o, digit_sel_o, blank_o});
    end
  endtask

  task automatic test_blink;
    bit ok;
    logic [3:0] want;
    press(1, 1);
    press(1, 1);
    st = 1'b0;
    tick(1);
    st = 1'b1;
    wait_for_sel(2'd1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL blink_enter_set1 got=%0d required=1", digit_sel_o);
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick(1);
      want = ((i / 4) % 2 == 1) ? 4'b0010 : 4'b0000;
      total++;
      if (blank_o !== want) begin
        bad++;
        $display("FAIL blink_set1_c%0d got=%b required=%b", i, blank_o, want);
      end
    end
    st = 1'b0;
    tick(1);
    st = 1'b1;
    wait_for_sel(2'd0, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL blink_enter_set0 got=%0d required=0", digit_sel_o);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick(1);
      want = (i >= 4) ? 4'b0001 : 4'b0000;
      total++;
      if (blank_o !== want) begin
        bad++;
        $display("FAIL blink_set0_c%0d got=%b required=%b", i, blank_o, want);
      end
    end
    press(1, 1);
    total++;
    if (edit_o !== 1'b0 || blank_o !== 4'b0000) begin
      bad++;
      $display("FAIL blink_exit got=%b/%b required=0/0000", edit_o, blank_o);
    end
  endtask

  task automatic test_priority;
    press(1, 1);
    press(0, 1);
    total++;
    if ({edit_o, run_o, digit_sel_o} !== 4'b1011) begin
      bad++;
      $display("FAIL ss_in_set3 got=%b required=1011",
               {edit_o, run_o, digit_sel_o});
    end
    press(1, 1);
    st = 1'b0;
    ch = 1'b0;
    tick(1);
    st = 1'b1;
    ch = 1'b1;
    tick(6);
    total++;
    if (digit_sel_o !== 2'd1 || edit_o !== 1'b1) begin
      bad++;
      $display("FAIL set_chg_same got=%0d required=1", digit_sel_o);
    end
    press(1, 1);
    press(1, 1);
    exp_q.push_back(4);
    press(2, 1);
    total++;
    if (exp_q.size() != 0 || edit_o !== 1'b0) begin
      bad++;
      $display("FAIL clr_stop got=%0d/%b required=0/0", exp_q.size(), edit_o);
    end
    press(0, 1);
    press(2, 1);
    total++;
    if (run_o !== 1'b1) begin
      bad++;
      $display("FAIL chg_in_run got=%b required=1", run_o);
    end
    press(0, 1);
    total++;
    if (run_o !== 1'b0) begin
      bad++;
      $display("FAIL final_stop got=%b required=0", run_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_start_stop;
    test_set_inc;
    test_blink;
    test_priority;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
